// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: two requester handshakes plus the shared result bus of the BCD converter
interface bcd_conv_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic                  req0_valid;
    logic [DATA_W-1:0]     req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_W-1:0]     req1_data;
    logic                  req1_ready;
    logic                  busy;
    logic                  done;
    logic                  done_id;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, busy, done, done_id, bcd_out
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, busy, done, done_id, bcd_out
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: two requesters share one iterative shift-and-add-3 binary-to-BCD converter
// Define BCD_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module bcd_conv_arbiter #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input logic             clk,
    input logic             rst,
    bcd_conv_arbiter_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    if (DATA_W < 4 || DATA_W > 16) begin : g_bad_width
        $error("DATA_W must be within 4..16");
    end
    if (pow10(DIGITS) <= (longint'(1) << DATA_W) - 1) begin : g_bad_digits
        $error("DIGITS too small for DATA_W");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   sr;
    logic [BW-1:0]       scratch;
    logic [BW-1:0]       adj;
    logic [BW+DATA_W-1:0] sh;
    logic [CW-1:0]       count;
    logic                cur_id;
    logic                busy_r;
    logic                done_r;
    logic                done_id_r;
    logic [BW-1:0]       bcd_r;
    logic                grant;
    logic                take;
    logic [DATA_W-1:0]   din;

`ifdef BCD_ARB_RR_EN
    logic ptr;
    assign grant = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
`else
    assign grant = !bus.req0_valid && bus.req1_valid;
`endif

    assign bus.req0_ready = !rst && state == IDLE && bus.req0_valid && !grant;
    assign bus.req1_ready = !rst && state == IDLE && bus.req1_valid && grant;
    assign take           = bus.req0_ready || bus.req1_ready;
    assign din            = grant ? bus.req1_data : bus.req0_data;

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++)
            adj[4*d +: 4] = scratch[4*d +: 4] >= 4'd5 ? scratch[4*d +: 4] + 4'd3 : scratch[4*d +: 4];
    end

    assign sh = {adj, sr} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            scratch   <= '0;
            count     <= '0;
            cur_id    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            bcd_r     <= '0;
`ifdef BCD_ARB_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (take) begin
                    sr      <= din;
                    scratch <= '0;
                    count   <= '0;
                    cur_id  <= grant;
                    busy_r  <= 1'b1;
                    state   <= SHIFT;
`ifdef BCD_ARB_RR_EN
                    ptr     <= !grant;
`endif
                end
                SHIFT: begin
                    {scratch, sr} <= sh;
                    count         <= count + 1'b1;
                    // this edge finishes the last of DATA_W iterations
                    if (count == CW'(DATA_W - 1)) begin
                        bcd_r     <= sh[BW+DATA_W-1 -: BW];
                        done_id_r <= cur_id;
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.bcd_out = bcd_r;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed scenario checks of the shared BCD converter arbiter
module tb_bcd_conv_arbiter;
    localparam int DATA_W = 8;
    localparam int DIGITS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

    bcd_conv_arbiter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [11:0] dec_model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic do_req(input bit id, input logic [7:0] d, output bit got, output int lat,
                          output logic [11:0] bcd, output logic rid, output logic done_next);
        got = 1'b0; lat = 40; bcd = 'x; rid = 1'bx; done_next = 1'bx;
        @(posedge clk); #1;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = k; bcd = bus.bcd_out; rid = bus.done_id; break; end
        end
        @(negedge clk);
        done_next = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req0_valid = 1'b1; bus.req0_data = 8'd5;
        @(posedge clk); @(negedge clk);
        tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b expected 0", bus.req0_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.done_id !== 1'b0) begin fails++; $display("FAIL reset_done_id: got %b expected 0", bus.done_id); end
        tests++; if (bus.bcd_out !== 12'h000) begin fails++; $display("FAIL reset_bcd: got %h expected 000", bus.bcd_out); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_req0_255();
        bit got; int lat; logic [11:0] bcd; logic rid, dn;
        do_req(1'b0, 8'd255, got, lat, bcd, rid, dn);
        tests++; if (!got || lat != 8) begin fails++; $display("FAIL r255_latency: got accept=%0d lat=%0d expected accept=1 lat=8", got, lat); end
        tests++; if (bcd !== 12'h255) begin fails++; $display("FAIL r255_bcd: got %h expected 255", bcd); end
        tests++; if (rid !== 1'b0) begin fails++; $display("FAIL r255_id: got %b expected 0", rid); end
        tests++; if (dn !== 1'b0) begin fails++; $display("FAIL r255_pulse: done after pulse %b expected 0", dn); end
        tests++; if (bus.bcd_out !== 12'h255) begin fails++; $display("FAIL r255_hold: got %h expected 255", bus.bcd_out); end
    endtask

    task automatic test_req1_seq();
        logic [7:0]  vals [3] = '{8'd0, 8'd9, 8'd100};
        logic [11:0] exps [3] = '{12'h000, 12'h009, 12'h100};
        bit got; int lat; logic [11:0] bcd; logic rid, dn;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, vals[i], got, lat, bcd, rid, dn);
            tests++; if (!got || bcd !== exps[i]) begin fails++; $display("FAIL r1seq_bcd[%0d]: got %h expected %h", i, bcd, exps[i]); end
            tests++; if (rid !== 1'b1) begin fails++; $display("FAIL r1seq_id[%0d]: got %b expected 1", i, rid); end
            tests++; if (dn !== 1'b0 || lat != 8) begin fails++; $display("FAIL r1seq_pulse[%0d]: got next=%b lat=%0d expected next=0 lat=8", i, dn, lat); end
        end
    endtask

    task automatic test_arbitration();
        int n = 0; bit r1seen = 1'b0; bit r1exp;
        logic [11:0] rb [4]; logic ri [4];
        logic [11:0] eb; logic ei;
`ifdef BCD_ARB_RR_EN
        r1exp = 1'b1;
`else
        r1exp = 1'b0;
`endif
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'd12;
        bus.req1_valid = 1'b1; bus.req1_data = 8'd34;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (bus.req1_ready) r1seen = 1'b1;
            if (bus.done) begin
                rb[n] = bus.bcd_out; ri[n] = bus.done_id; n++;
                if (n == 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tests++; if (n != 4) begin fails++; $display("FAIL arb_count: got %0d results expected 4", n); end
        tests++; if (r1seen !== r1exp) begin fails++; $display("FAIL arb_req1_ready: got seen=%b expected %b", r1seen, r1exp); end
        for (int i = 0; i < n; i++) begin
`ifdef BCD_ARB_RR_EN
            eb = (i % 2) ? 12'h034 : 12'h012; ei = 1'((i % 2));
`else
            eb = 12'h012; ei = 1'b0;
`endif
            tests++; if (rb[i] !== eb || ri[i] !== ei) begin fails++; $display("FAIL arb_result[%0d]: got %h id %b expected %h id %b", i, rb[i], ri[i], eb, ei); end
        end
    endtask

    task automatic test_back_to_back();
        bit got0 = 1'b0; int acc = -1; int lat = 40;
        logic [11:0] first_bcd = 'x; logic [11:0] bcd = 'x; logic rid = 1'bx;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'd7;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req0_ready) begin got0 = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'd45;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.done) first_bcd = bus.bcd_out;
            if (bus.req1_ready) begin acc = k; break; end
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = k; bcd = bus.bcd_out; rid = bus.done_id; break; end
        end
        tests++; if (!got0) begin fails++; $display("FAIL b2b_accept0: got 0 expected 1"); end
        tests++; if (acc != DATA_W + 2) begin fails++; $display("FAIL b2b_gap: got %0d expected %0d", acc, DATA_W + 2); end
        tests++; if (first_bcd !== 12'h007) begin fails++; $display("FAIL b2b_first: got %h expected 007", first_bcd); end
        tests++; if (bcd !== 12'h045 || rid !== 1'b1 || lat != 8) begin fails++; $display("FAIL b2b_second: got %h id %b lat %0d expected 045 id 1 lat 8", bcd, rid, lat); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0; bit got; int lat; logic [11:0] bcd; logic rid, dn;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'd200;
        @(negedge clk);
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL rmid_accept: got %b expected 1", bus.req0_ready); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.bcd_out !== 12'h000) begin fails++; $display("FAIL rmid_state: got busy %b bcd %h expected busy 0 bcd 000", bus.busy, bus.bcd_out); end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rmid_no_done: got done pulse expected none"); end
        do_req(1'b0, 8'd200, got, lat, bcd, rid, dn);
        tests++; if (!got || bcd !== 12'h200 || rid !== 1'b0) begin fails++; $display("FAIL rmid_retry: got %h id %b expected 200 id 0", bcd, rid); end
    endtask

    task automatic test_sweep();
        bit got; int lat; logic [11:0] bcd; logic rid, dn; bit ok;
        for (int v = 0; v < 256; v++) begin
            do_req(1'b0, 8'(v), got, lat, bcd, rid, dn);
            tests++; if (!got || bcd !== dec_model(v)) begin fails++; $display("FAIL sweep_bcd[%0d]: got %h expected %h", v, bcd, dec_model(v)); end
            ok = 1'b1;
            for (int d = 0; d < DIGITS; d++) if (!(bcd[4*d +: 4] <= 4'd9)) ok = 1'b0;
            tests++; if (!ok) begin fails++; $display("FAIL sweep_digit[%0d]: got %h expected every digit <= 9", v, bcd); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0;
        test_reset();
        test_req0_255();
        test_req1_seq();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
